// File: rtl/match_event_logger.sv
// match_event_logger: timestamps each qualified match pulse from the sequence
// detector and queues it in a small FIFO drained over a valid/ready port.
// Keeps a saturating match count and a sticky overflow flag.
// Optional feature macro: EVLOG_DROP_CNT_EN adds a saturating drop counter
// output (drop_cnt); without it, overflow is the only loss indication.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det,
  input  logic             en,
  input  logic             clr,
  output logic [TS_W-1:0]  ts_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
`ifdef EVLOG_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [TS_W-1:0]  ts_data_q, ts_data_d;
  logic             ts_valid_q, ts_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic ev, pop, full, full_eff, push, drop;

  // Event qualification, FIFO bookkeeping and next-state for all registers.
  always_comb begin
    ev       = det & en & ~clr;
    pop      = ts_valid_q & ts_ready;
    full     = (occ_q == FULL_OCC);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    full_eff = full & ~pop;
    push     = ev & ~full_eff;
    drop     = ev & full_eff;

    ts_d     = ts_q + TS_W'(1);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (push) begin
      mem_d[wr_ptr_q] = ts_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase

    count_d    = (ev && (count_q != {CNT_W{1'b1}})) ? count_q + CNT_W'(1) : count_q;
    overflow_d = overflow_q | drop;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end

    // Head register is loaded from the post-update array so a push into an
    // empty FIFO and a pop that exposes the next entry both appear without a
    // bubble; the output holds its value while nothing changes at the head.
    ts_valid_d = (occ_d != '0);
    ts_data_d  = ts_valid_d ? mem_d[rd_ptr_d] : ts_data_q;
  end

  // Control and status registers; rst overrides clr and everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ts_data_q  <= '0;
      ts_valid_q <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ts_data_q  <= ts_data_d;
      ts_valid_q <= ts_valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ts_data  = ts_data_q;
  assign ts_valid = ts_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef EVLOG_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of events discarded because the FIFO was full.
  always_comb begin
    drop_cnt_d = (drop && (drop_cnt_q != {CNT_W{1'b1}})) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    if (clr) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Testbench for match_event_logger: directed stimulus with a scoreboard queue
// of expected timestamps checked by a monitor on every handshake, plus direct
// status checks. A second small instance covers counter saturation and
// timestamp wrap.
`timescale 1ns/1ps
module tb_match_event_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        det, en, clr, ts_ready;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic [7:0]  count;
  logic        overflow;

  logic        rst2 = 1'b1;
  logic        det2, en2, clr2, ready2;
  logic [3:0]  ts_data2;
  logic        ts_valid2;
  logic [1:0]  count2;
  logic        overflow2;

`ifdef EVLOG_DROP_CNT_EN
  logic [7:0]  drop_cnt;
  logic [1:0]  drop_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] tb_ts;

  // Reference timestamp: equals the DUT's counter when sampled #1 after an edge.
  always @(posedge clk) tb_ts <= rst ? 16'd0 : tb_ts + 16'd1;

  match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .det(det), .en(en), .clr(clr),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .count(count), .overflow(overflow)
`ifdef EVLOG_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst2), .det(det2), .en(en2), .clr(clr2),
    .ts_data(ts_data2), .ts_valid(ts_valid2), .ts_ready(ready2),
    .count(count2), .overflow(overflow2)
`ifdef EVLOG_DROP_CNT_EN
    , .drop_cnt(drop_cnt2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input logic [15:0] v);
    int n;
    n = 0;
    while (tb_ts !== v && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_ts: got %0d expected %0d (timeout)", tb_ts, v);
    end
  endtask

  initial begin
    det = 0; en = 0; clr = 0; ts_ready = 0;
    det2 = 0; en2 = 1; clr2 = 0; ready2 = 0;

    // Monitor: pops the scoreboard on every accepted handshake.
    fork
      forever begin : mon
        logic [15:0] e;
        @(negedge clk);
        if (!rst && ts_valid && ts_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %0d expected none", ts_data);
          end else begin
            e = exp_q.pop_front();
            if (ts_data !== e) begin
              errors++;
              $display("FAIL pop_data: got %0d expected %0d", ts_data, e);
            end
          end
        end
      end
    join_none

    // Reset for two cycles
    repeat (2) step();
    check("rst_valid", ts_valid, 0);
    check("rst_data", ts_data, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
`ifdef EVLOG_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    rst = 0;

    // Single event at ts=5
    wait_ts(16'd5);
    det = 1; en = 1;
    exp_q.push_back(16'd5);
    step();
    det = 0;
    check("single_valid", ts_valid, 1);
    check("single_data", ts_data, 5);
    check("single_count", count, 1);
    ts_ready = 1;
    step();
    ts_ready = 0;
    check("single_drained", ts_valid, 0);

    // Clear count before the fill test
    wait_ts(16'd8);
    clr = 1;
    step();
    clr = 0;
    check("clr_count", count, 0);

    // Fill and overflow: events at ts 10..15, no reads
    wait_ts(16'd10);
    det = 1;
    for (int i = 10; i < 14; i++) exp_q.push_back(16'(i));
    repeat (6) step();
    det = 0;
    check("fill_count", count, 6);
    check("fill_overflow", overflow, 1);
    check("fill_valid", ts_valid, 1);
    check("fill_head", ts_data, 10);
`ifdef EVLOG_DROP_CNT_EN
    check("fill_drop_cnt", drop_cnt, 2);
`endif
    ts_ready = 1;
    repeat (4) step();
    ts_ready = 0;
    check("fill_drained_valid", ts_valid, 0);
    check("fill_drained_queue", exp_q.size(), 0);
    check("overflow_sticky", overflow, 1);

    // Clear, then enable gating
    clr = 1;
    step();
    clr = 0;
    check("clr_overflow", overflow, 0);
    en = 0; det = 1;
    repeat (3) step();
    det = 0;
    check("gate_valid", ts_valid, 0);
    check("gate_count", count, 0);

    // Simultaneous push and pop while full
    wait_ts(16'd40);
    en = 1; det = 1;
    for (int i = 40; i < 44; i++) exp_q.push_back(16'(i));
    repeat (4) step();
    check("full_valid", ts_valid, 1);
    check("full_count", count, 4);
    ts_ready = 1;
    exp_q.push_back(16'd44);
    step();
    det = 0; ts_ready = 0;
    check("pushpop_overflow", overflow, 0);
    check("pushpop_count", count, 5);
    check("pushpop_head", ts_data, 41);
    ts_ready = 1;
    repeat (4) step();
    ts_ready = 0;
    check("pushpop_occ4_empty", ts_valid, 0);
    check("pushpop_queue", exp_q.size(), 0);

    // Clear mid-burst with det in the same cycle
    wait_ts(16'd60);
    det = 1;
    repeat (3) step();
    clr = 1;
    step();
    clr = 0; det = 0;
    check("clrmid_valid", ts_valid, 0);
    check("clrmid_count", count, 0);
    check("clrmid_overflow", overflow, 0);
    wait_ts(16'd66);
    det = 1;
    exp_q.push_back(16'd66);
    step();
    det = 0;
    check("postclr_data", ts_data, 66);
    check("postclr_count", count, 1);
    ts_ready = 1;
    step();
    ts_ready = 0;

    // Reset mid-burst discards stored entries
    det = 1;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0; det = 0;
    check("rstmid_valid", ts_valid, 0);
    check("rstmid_count", count, 0);

    // Small instance: CNT_W=2 saturation and TS_W=4 wrap
    rst2 = 1;
    repeat (2) step();
    rst2 = 0;
    repeat (17) @(posedge clk);
    #1;
    det2 = 1;
    repeat (5) step();
    det2 = 0;
    check("wrap_valid", ts_valid2, 1);
    check("wrap_data", ts_data2, 1);
    check("sat_count", count2, 3);
    check("small_overflow", overflow2, 1);
`ifdef EVLOG_DROP_CNT_EN
    check("small_drop_cnt", drop_cnt2, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial sequence detector's one-cycle match pulse. Every accepted pulse is stamped with a free-running cycle timestamp and pushed into a small FIFO, which a host drains over a valid/ready interface. The block also keeps a saturating match count and a sticky overflow flag, so bursts of matches are never silently lost.

## Interface
- `TS_W`, 16: timestamp width; free-running counter wraps modulo 2^TS_W.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 8: match counter width; saturating.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock, synchronous active-high reset as decided.
- `det`  in  1  match pulse from the detector; one cycle high per match.
- `en`  in  1  logging enable; `det` is ignored while low.
- `clr`  in  1  synchronous soft clear of FIFO, `count` and `overflow`.
- `ts_data`  out  TS_W  timestamp at the head of the FIFO.
- `ts_valid`  out  1  head entry is valid.
- `ts_ready`  in  1  consumer accepts the head entry.
- `count`  out  CNT_W  accepted matches since reset or clear.
- `overflow`  out  1  sticky; set when a match arrives while the FIFO is full.

## Operation
- `ts` is the internal timestamp counter:
  - Reset value 0.
  - Increments every cycle, including during `clr`.
  - Wraps to 0 after all-ones.
- Event qualification: `ev = det & en & ~clr`.
- Pop: `ts_valid & ts_ready`. Push: `ev & ~full_eff`, where `full_eff = full & ~pop`. A push into a full FIFO succeeds only if a pop occurs in the same cycle.
- Push stores the `ts` value of the cycle in which `det` is sampled high.
- Drop: `ev & full_eff`. The entry is discarded and `overflow` is set to 1; it stays set until `rst` or `clr`.
- `count` increments on every `ev`, including drops. It saturates at 2^CNT_W−1 and does not wrap.
- FIFO occupancy states:
  - EMPTY: `ts_valid` = 0.
  - PARTIAL.
  - FULL: occupancy equals DEPTH.
  - Pointers are log2(DEPTH) bits and wrap. Full/empty is resolved with an extra occupancy bit.
- `ts_data` is don't-care while `ts_valid` = 0. It is stable while `ts_valid` = 1 and `ts_ready` = 0.
- `clr` empties the FIFO and zeroes `count` and `overflow`. `ts` is untouched. A `det` in the same cycle as `clr` is ignored.
- `rst` overrides everything. Reset values:
  - `ts` = 0, FIFO empty.
  - `ts_valid` = 0, `ts_data` = 0.
  - `count` = 0, `overflow` = 0.
  - Drop counter = 0.
- `rst` asserted mid-burst discards all stored entries.

## Timing
- Push latency: `det` high at edge N → `ts_valid` = 1 after edge N+1 when the FIFO was empty. `ts_data` = `ts` value at edge N.
- `count` and `overflow` update at the same edge as the push or drop decision; visible one cycle after `det`.
- Pop: the head advances on the edge where `ts_valid & ts_ready`. The next entry is presented in the following cycle, with no bubble.
- Throughput: one push and one pop per cycle sustained.
- All outputs are registered. There is no combinational path from `ts_ready` to `ts_valid`.

## Configuration
- `EVLOG_DROP_CNT_EN`
  - Defined: adds output `drop_cnt` (CNT_W bits). It increments on each dropped event, saturates at all-ones, and is cleared by `rst`/`clr`.
  - Undefined: the port and its logic are absent; `overflow` is the only loss indication.

## Test plan
- Reset, single event: `rst` for 2 cycles, then `det` pulse at `ts` = 5 with `en` = 1 and `ts_ready` = 0. Required: `ts_valid` = 1 next cycle, `ts_data` = 5, `count` = 1.
- Enable gating: `det` pulses with `en` = 0. Required: `ts_valid` stays 0, `count` stays 0.
- Fill and overflow: DEPTH = 4, 6 `det` pulses at `ts` = 10..15 with `ts_ready` = 0.
  - FIFO holds 10, 11, 12, 13; `overflow` = 1; `count` = 6.
  - `drop_cnt` = 2 when `EVLOG_DROP_CNT_EN` is defined.
  - Draining then yields 10, 11, 12, 13 in order.
- Simultaneous push/pop when full: FIFO full, `det` and `ts_ready` high together. Required: the pop succeeds, the new timestamp is stored, `overflow` stays 0, occupancy stays 4.
- Clear mid-burst: 3 entries stored, then `clr` pulsed together with `det`. Required next cycle: `ts_valid` = 0, `count` = 0, `overflow` = 0, `ts` still incrementing.
- Saturation and wrap: CNT_W = 2 with 5 events. Required: `count` = 3. Separately, TS_W = 4 with an event sampled after 17 cycles from reset release: stored `ts` = 1.
